// File: rtl/snd_arbiter_if.sv
// Sound-event arbiter bus: timebase enable, event requests, per-event tone
// config, and the granted/tone outputs.
interface snd_arbiter_if #(
  parameter int N  = 3,
  parameter int HW = 10,
  parameter int LW = 16
);
  logic            ce;
  logic [N-1:0]    req;
  logic [N*HW-1:0] half;
  logic [N*LW-1:0] len;
  logic [N-1:0]    grant;
  logic            busy;
  logic            sound;

  modport master (output ce, req, half, len, input grant, busy, sound);
  modport slave  (input ce, req, half, len, output grant, busy, sound);
endinterface

// File: rtl/snd_arbiter.sv
// Fixed-priority sound event arbiter: latches event pulses, plays one square
// tone at a time, lower index preempts higher index.
//
// state | meaning
// IDLE  | no note playing; next edge grants the lowest pending event
// PLAY  | note active; ce advances tone and length counters
module snd_arbiter #(
  parameter int N  = 3,
  parameter int HW = 10,
  parameter int LW = 16
) (
  input logic          clock,
  input logic          reset,
  snd_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, PLAY} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [HW-1:0] half_q, half_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [LW-1:0] len_q, len_d;
  logic          sound_q, sound_d;

  logic [IW-1:0] sel;
  logic          sel_vld;
  logic [HW-1:0] sel_half;
  logic [LW-1:0] sel_len;
  logic          preempt;
  logic          retrig;
  logic          start;
  logic          regrant;

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel     = IW'(i);
        sel_vld = 1'b1;
      end
    end
  end

  assign sel_half = bus.half[sel*HW +: HW];
  assign sel_len  = bus.len[sel*LW +: LW];

  // grant_q - 1 on a one-hot vector marks every higher-priority index
  assign preempt = (state_q == PLAY) && (|(pending_q & (grant_q - N'(1))));
  assign retrig  = (state_q == PLAY) && (|(bus.req & grant_q));
  assign start   = sel_vld && ((state_q == IDLE) || preempt);
  assign regrant = start && (sel_len != '0);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    hcnt_d    = hcnt_q;
    half_d    = half_q;
    lcnt_d    = lcnt_q;
    len_d     = len_q;
    sound_d   = sound_q;
    pending_d = pending_q | (bus.req & ((state_q == PLAY) ? ~grant_q : '1));

    // A zero-length event is consumed without ever being granted
    if (start) begin
      pending_d[sel] = 1'b0;
    end

    if (regrant) begin
      state_d = PLAY;
      grant_d = N'(1) << sel;
      hcnt_d  = sel_half;
      half_d  = sel_half;
      lcnt_d  = sel_len;
      len_d   = sel_len;
      sound_d = (sel_half != '0);
    end else if (state_q == PLAY) begin
      if (bus.ce && (half_q != '0)) begin
        if (hcnt_q == HW'(1)) begin
          hcnt_d  = half_q;
          sound_d = ~sound_q;
        end else begin
          hcnt_d = hcnt_q - HW'(1);
        end
      end
      if (retrig) begin
        lcnt_d = len_q;
      end else if (bus.ce) begin
        if (lcnt_q == LW'(1)) begin
          state_d = IDLE;
          grant_d = '0;
          sound_d = 1'b0;
          lcnt_d  = '0;
          hcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q - LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      hcnt_q    <= '0;
      half_q    <= '0;
      lcnt_q    <= '0;
      len_q     <= '0;
      sound_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      hcnt_q    <= hcnt_d;
      half_q    <= half_d;
      lcnt_q    <= lcnt_d;
      len_q     <= len_d;
      sound_q   <= sound_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = |grant_q;
  assign bus.sound = sound_q;
endmodule

// File: tb/tb_snd_arbiter.sv
// Directed bench for snd_arbiter: N=3, HW=4, LW=8, ce every 8th clock.
module tb_snd_arbiter;
  localparam int N  = 3;
  localparam int HW = 4;
  localparam int LW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ce_div = 0;

  snd_arbiter_if #(.N(N), .HW(HW), .LW(LW)) bus ();
  snd_arbiter #(.N(N), .HW(HW), .LW(LW)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  initial begin
    bus.ce = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      ce_div = (ce_div + 1) % 8;
      bus.ce = (ce_div == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want summary");
    $fatal(1);
  end

  task automatic set_cfg(input int i, input int h, input int l);
    bus.half[i*HW +: HW] = HW'(h);
    bus.len[i*LW +: LW]  = LW'(l);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (bus.grant !== 3'b000) begin n_bad++; $display("FAIL rst_grant: got %b want 000", bus.grant); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.sound !== 1'b0) begin n_bad++; $display("FAIL rst_sound: got %b want 0", bus.sound); end
    n_cmp++; if (dut.pending_q !== 3'b000) begin n_bad++; $display("FAIL rst_pending: got %b want 000", dut.pending_q); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_tone();
    logic [7:0] pat;
    int ticks, c;
    pat = 8'b0011_0011;
    set_cfg(0, 2, 8);
    bus.req = 3'b001;
    @(negedge clock); bus.req = '0;
    n_cmp++; if (bus.grant !== 3'b000) begin n_bad++; $display("FAIL t1_latency: got %b want 000", bus.grant); end
    @(negedge clock);
    n_cmp++; if (bus.grant !== 3'b001) begin n_bad++; $display("FAIL t1_grant: got %b want 001", bus.grant); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy: got %b want 1", bus.busy); end
    ticks = 0; c = 0;
    while (ticks < 8 && c < 400) begin
      if (bus.ce) begin
        n_cmp++; if (bus.sound !== pat[ticks]) begin n_bad++; $display("FAIL t1_sound_ce%0d: got %b want %b", ticks + 1, bus.sound, pat[ticks]); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy_ce%0d: got %b want 1", ticks + 1, bus.busy); end
        ticks++;
      end
      @(negedge clock); c++;
    end
    n_cmp++; if (ticks != 8) begin n_bad++; $display("FAIL t1_timeout: got %0d ce want 8", ticks); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t1_end_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.sound !== 1'b0) begin n_bad++; $display("FAIL t1_end_sound: got %b want 0", bus.sound); end
  endtask

  task automatic test_back_to_back();
    int ticks, c;
    set_cfg(1, 3, 4);
    set_cfg(2, 3, 4);
    bus.req = 3'b110;
    @(negedge clock); bus.req = '0;
    @(negedge clock);
    n_cmp++; if (bus.grant !== 3'b010) begin n_bad++; $display("FAIL t2_grant1: got %b want 010", bus.grant); end
    ticks = 0; c = 0;
    while (ticks < 4 && c < 400) begin
      if (bus.ce) ticks++;
      if (bus.grant !== 3'b010) begin n_cmp++; n_bad++; $display("FAIL t2_hold1: got %b want 010", bus.grant); end
      @(negedge clock); c++;
    end
    n_cmp++; if (ticks != 4) begin n_bad++; $display("FAIL t2_timeout1: got %0d ce want 4", ticks); end
    n_cmp++; if (bus.grant !== 3'b000) begin n_bad++; $display("FAIL t2_gap: got %b want 000", bus.grant); end
    @(negedge clock);
    n_cmp++; if (bus.grant !== 3'b100) begin n_bad++; $display("FAIL t2_grant2: got %b want 100", bus.grant); end
    ticks = 0; c = 0;
    while (ticks < 4 && c < 400) begin
      if (bus.ce) ticks++;
      if (bus.grant !== 3'b100) begin n_cmp++; n_bad++; $display("FAIL t2_hold2: got %b want 100", bus.grant); end
      @(negedge clock); c++;
    end
    n_cmp++; if (ticks != 4) begin n_bad++; $display("FAIL t2_timeout2: got %0d ce want 4", ticks); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t2_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_preempt();
    int ticks, c;
    bit resumed;
    set_cfg(2, 3, 20);
    set_cfg(0, 2, 3);
    bus.req = 3'b100;
    @(negedge clock); bus.req = '0;
    @(negedge clock);
    n_cmp++; if (bus.grant !== 3'b100) begin n_bad++; $display("FAIL t3_grant2: got %b want 100", bus.grant); end
    ticks = 0; c = 0;
    while (ticks < 5 && c < 400) begin
      if (bus.ce) ticks++;
      if (ticks == 5) bus.req = 3'b001;
      else begin @(negedge clock); c++; end
    end
    @(negedge clock); bus.req = '0;
    n_cmp++; if (bus.grant !== 3'b100) begin n_bad++; $display("FAIL t3_pending_stage: got %b want 100", bus.grant); end
    @(negedge clock);
    n_cmp++; if (bus.grant !== 3'b001) begin n_bad++; $display("FAIL t3_preempt: got %b want 001", bus.grant); end
    n_cmp++; if (bus.sound !== 1'b1) begin n_bad++; $display("FAIL t3_sound: got %b want 1", bus.sound); end
    ticks = 0; c = 0;
    while (ticks < 3 && c < 400) begin
      if (bus.ce) ticks++;
      @(negedge clock); c++;
    end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t3_end: got %b want 0", bus.busy); end
    resumed = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (bus.busy) resumed = 1'b1;
    end
    n_cmp++; if (resumed !== 1'b0) begin n_bad++; $display("FAIL t3_no_resume: got %b want 0", resumed); end
  endtask

  task automatic test_silent();
    int ticks, c;
    set_cfg(1, 0, 6);
    bus.req = 3'b010;
    @(negedge clock); bus.req = '0;
    @(negedge clock);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t4_busy: got %b want 1", bus.busy); end
    ticks = 0; c = 0;
    while (ticks < 6 && c < 400) begin
      if (bus.ce) ticks++;
      n_cmp++; if (bus.sound !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL t4_silent: got sound=%b busy=%b want sound=0 busy=1", bus.sound, bus.busy); end
      @(negedge clock); c++;
    end
    n_cmp++; if (ticks != 6) begin n_bad++; $display("FAIL t4_timeout: got %0d ce want 6", ticks); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t4_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_drop_and_reset();
    bit seen;
    set_cfg(0, 2, 0);
    bus.req = 3'b001;
    @(negedge clock); bus.req = '0;
    @(negedge clock);
    n_cmp++; if (bus.grant !== 3'b000) begin n_bad++; $display("FAIL t5_drop_grant: got %b want 000", bus.grant); end
    n_cmp++; if (dut.pending_q !== 3'b000) begin n_bad++; $display("FAIL t5_drop_pending: got %b want 000", dut.pending_q); end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (bus.busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL t5_drop_idle: got %b want 0", seen); end
    set_cfg(1, 2, 10);
    bus.req = 3'b010;
    @(negedge clock); bus.req = '0;
    @(negedge clock);
    n_cmp++; if (bus.grant !== 3'b010) begin n_bad++; $display("FAIL t5_grant: got %b want 010", bus.grant); end
    repeat (3) @(negedge clock);
    bus.req = 3'b100;
    reset = 1'b1;
    @(negedge clock);
    bus.req = '0;
    reset = 1'b0;
    n_cmp++; if (bus.grant !== 3'b000) begin n_bad++; $display("FAIL t5_rst_grant: got %b want 000", bus.grant); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t5_rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.sound !== 1'b0) begin n_bad++; $display("FAIL t5_rst_sound: got %b want 0", bus.sound); end
    n_cmp++; if (dut.pending_q !== 3'b000) begin n_bad++; $display("FAIL t5_rst_pending: got %b want 000", dut.pending_q); end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (bus.busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL t5_rst_idle: got %b want 0", seen); end
  endtask

  task automatic test_retrigger();
    int ticks, c;
    bit seen;
    set_cfg(1, 2, 4);
    bus.req = 3'b010;
    @(negedge clock); bus.req = '0;
    @(negedge clock);
    n_cmp++; if (bus.grant !== 3'b010) begin n_bad++; $display("FAIL t6_grant: got %b want 010", bus.grant); end
    ticks = 0; c = 0;
    while (ticks < 7 && c < 400) begin
      bus.req = '0;
      if (bus.ce) begin
        ticks++;
        if (ticks == 3) bus.req = 3'b010;
      end
      if (bus.busy !== 1'b1) begin n_cmp++; n_bad++; $display("FAIL t6_hold_ce%0d: got %b want 1", ticks, bus.busy); end
      @(negedge clock); c++;
    end
    bus.req = '0;
    n_cmp++; if (ticks != 7) begin n_bad++; $display("FAIL t6_timeout: got %0d ce want 7", ticks); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t6_end: got %b want 0", bus.busy); end
    seen = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (bus.busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL t6_no_repeat: got %b want 0", seen); end
  endtask

  initial begin
    bus.req  = '0;
    bus.half = '0;
    bus.len  = '0;
    test_reset();
    test_tone();
    test_back_to_back();
    test_preempt();
    test_silent();
    test_drop_and_reset();
    test_retrigger();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
